// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stall, taken-branch flush, data-memory wait/timeout.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs2,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        pc_write,
  output logic        ifid_not_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        pipe_hold,
  output logic        mem_err,
  output logic [1:0]  state,
  output logic [31:0] lu_stall_cnt,
  output logic [31:0] mem_stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TMO = WW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          hazard, mem_stall;

  assign hazard    = ex_mem_read & (ex_rd != 5'd0) &
                     ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
  assign mem_stall = dmem_req & ~dmem_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    pc_write       = 1'b1;
    ifid_not_write = 1'b0;
    ifid_flush     = 1'b0;
    idex_bubble    = 1'b0;
    pipe_hold      = 1'b0;
    mem_err        = 1'b0;
    state_d        = state_q;
    wait_d         = wait_q;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (state_q)
        MEM_WAIT: begin
          if (dmem_ack) begin
            // Access completes: ordinary RUN priorities with the memory stall gone.
            state_d = RUN;
            wait_d  = '0;
            if (branch_taken) begin
              ifid_flush  = 1'b1;
              idex_bubble = 1'b1;
            end else if (hazard) begin
              pc_write       = 1'b0;
              ifid_not_write = 1'b1;
              idex_bubble    = 1'b1;
            end
          end else begin
            pc_write       = 1'b0;
            ifid_not_write = 1'b1;
            pipe_hold      = 1'b1;
            if (wait_q == TMO) state_d = MEM_ERR;
            else               wait_d  = wait_q + WW'(1);
          end
        end
        MEM_ERR: begin
          mem_err     = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          pc_write    = 1'b0;
          state_d     = RUN;
          wait_d      = '0;
        end
        default: begin
          if (mem_stall) begin
            pc_write       = 1'b0;
            ifid_not_write = 1'b1;
            pipe_hold      = 1'b1;
            state_d        = MEM_WAIT;
            wait_d         = WW'(1);
          end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (hazard) begin
            pc_write       = 1'b0;
            ifid_not_write = 1'b1;
            idex_bubble    = 1'b1;
          end
        end
      endcase
    end
  end

  assign state = reset ? 2'd0 : state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_q, lu_d, mem_q, mem_d, fl_q, fl_d;
  logic        lu_inc;

  // Only the load-use stall asserts both write-inhibit and bubble.
  assign lu_inc = ifid_not_write & idex_bubble;
  assign lu_d   = (lu_inc && lu_q != 32'hFFFF_FFFF) ? lu_q + 32'd1 : lu_q;
  assign mem_d  = (pipe_hold && mem_q != 32'hFFFF_FFFF) ? mem_q + 32'd1 : mem_q;
  assign fl_d   = (ifid_flush && fl_q != 32'hFFFF_FFFF) ? fl_q + 32'd1 : fl_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lu_q  <= '0;
      mem_q <= '0;
      fl_q  <= '0;
    end else begin
      lu_q  <= lu_d;
      mem_q <= mem_d;
      fl_q  <= fl_d;
    end
  end

  assign lu_stall_cnt  = reset ? 32'd0 : lu_q;
  assign mem_stall_cnt = reset ? 32'd0 : mem_q;
  assign flush_cnt     = reset ? 32'd0 : fl_q;
`else
  assign lu_stall_cnt  = 32'd0;
  assign mem_stall_cnt = 32'd0;
  assign flush_cnt     = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed table-driven bench for hazard_stall_ctrl (MEM_TIMEOUT=4).
module tb_hazard_stall_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs2, ex_mem_read, branch_taken, dmem_req, dmem_ack;
  logic        pc_write, ifid_not_write, ifid_flush, idex_bubble, pipe_hold, mem_err;
  logic [1:0]  state;
  logic [31:0] lu_stall_cnt, mem_stall_cnt, flush_cnt;

  hazard_stall_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_write(pc_write), .ifid_not_write(ifid_not_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_hold(pipe_hold), .mem_err(mem_err),
    .state(state), .lu_stall_cnt(lu_stall_cnt), .mem_stall_cnt(mem_stall_cnt),
    .flush_cnt(flush_cnt)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected output encodings {pc_write, ifid_not_write, ifid_flush, idex_bubble, pipe_hold, mem_err}
  localparam logic [5:0] O_DEF  = 6'b100000;
  localparam logic [5:0] O_LU   = 6'b010100;
  localparam logic [5:0] O_BR   = 6'b101100;
  localparam logic [5:0] O_HOLD = 6'b010010;
  localparam logic [5:0] O_ERR  = 6'b001101;
  localparam logic [5:0] O_RST  = 6'b001100;

  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2;
    logic       uses2, mr;
    logic [4:0] rd;
    logic       br, req, ack;
    logic [5:0] e_out;
    logic [1:0] e_state;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int exp_lu = 0, exp_mem = 0, exp_fl = 0;
  string onames[6] = '{"pc_write", "ifid_not_write", "ifid_flush", "idex_bubble", "pipe_hold", "mem_err"};
  vec_t tbl[8];

  function automatic vec_t mkv(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic uses2, input logic mr, input logic [4:0] rd,
                               input logic br, input logic req, input logic ack,
                               input logic [5:0] eo, input logic [1:0] es);
    vec_t v;
    v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.uses2 = uses2; v.mr = mr; v.rd = rd;
    v.br = br; v.req = req; v.ack = ack; v.e_out = eo; v.e_state = es;
    return v;
  endfunction

  function automatic logic [31:0] cnt_exp(input int v);
`ifdef HAZARD_PERF_CNT_EN
    return 32'(v);
`else
    return 32'(v * 0);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drive at negedge, compare combinational outputs 1ns later
  task automatic run_vec(input string tag, input vec_t v);
    logic [5:0] act;
    @(negedge clk);
    reset = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs2 = v.uses2;
    ex_mem_read = v.mr; ex_rd = v.rd; branch_taken = v.br; dmem_req = v.req; dmem_ack = v.ack;
    #1;
    act = {pc_write, ifid_not_write, ifid_flush, idex_bubble, pipe_hold, mem_err};
    for (int k = 0; k < 6; k++) chk({tag, ".", onames[k]}, 32'(act[5-k]), 32'(v.e_out[5-k]));
    chk({tag, ".state"}, 32'(state), 32'(v.e_state));
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, ".lu_stall_cnt"}, lu_stall_cnt, cnt_exp(exp_lu));
    chk({tag, ".mem_stall_cnt"}, mem_stall_cnt, cnt_exp(exp_mem));
    chk({tag, ".flush_cnt"}, flush_cnt, cnt_exp(exp_fl));
  endtask

  vec_t idle_v, hold_r, hold_w;

  initial begin
    reset = 1'b1; id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_rd = '0; branch_taken = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;

    idle_v = mkv(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 0, O_DEF, 2'd0);
    hold_r = mkv(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 0, O_HOLD, 2'd0);
    hold_w = mkv(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 0, O_HOLD, 2'd1);

    tbl[0] = mkv(0, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0, O_LU,  2'd0); // load-use rs1
    tbl[1] = mkv(0, 5'd5, 5'd0, 0, 0, 5'd5, 0, 0, 0, O_DEF, 2'd0); // bubble cleared mem_read
    tbl[2] = mkv(0, 5'd0, 5'd0, 0, 1, 5'd0, 0, 0, 0, O_DEF, 2'd0); // rd=x0 never stalls
    tbl[3] = mkv(0, 5'd3, 5'd7, 0, 1, 5'd7, 0, 0, 0, O_DEF, 2'd0); // rs2 not used
    tbl[4] = mkv(0, 5'd3, 5'd7, 1, 1, 5'd7, 0, 0, 0, O_LU,  2'd0); // load-use rs2
    tbl[5] = mkv(0, 5'd5, 5'd0, 0, 1, 5'd5, 1, 0, 0, O_BR,  2'd0); // branch beats hazard
    tbl[6] = mkv(0, 5'd9, 5'd9, 1, 0, 5'd9, 1, 0, 0, O_BR,  2'd0); // branch alone
    tbl[7] = mkv(0, 5'd3, 5'd4, 1, 1, 5'd9, 0, 0, 0, O_DEF, 2'd0); // unrelated load

    // reset state
    run_vec("reset0", mkv(1, 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 0, O_RST, 2'd0));
    run_vec("reset1", mkv(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, O_RST, 2'd0));
    run_vec("idle", idle_v);
    chk_cnts("after_reset");

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), tbl[i]);
    exp_lu = 2; exp_fl = 2;
    run_vec("idle_a", idle_v);
    chk_cnts("after_table");

    // memory wait, ack on 4th cycle; mem_stall beats branch and hazard in cycle 1
    run_vec("mw1", mkv(0, 5'd5, 5'd0, 0, 1, 5'd5, 1, 1, 0, O_HOLD, 2'd0));
    run_vec("mw2", hold_w);
    run_vec("mw3", hold_w);
    run_vec("mw_ack", mkv(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 1, O_DEF, 2'd1));
    run_vec("mw_after", idle_v);
    exp_mem = 3;
    chk_cnts("after_mw");

    // timeout: 5 hold cycles, one MEM_ERR, back to RUN
    run_vec("to1", hold_r);
    for (int i = 2; i <= 5; i++) run_vec($sformatf("to%0d", i), hold_w);
    run_vec("to_err", mkv(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 0, O_ERR, 2'd2));
    run_vec("to_after", idle_v);
    exp_mem = 8; exp_fl = 3;
    chk_cnts("after_to");

    // reset during 2nd MEM_WAIT cycle
    run_vec("rw1", hold_r);
    run_vec("rw_rst", mkv(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 0, O_RST, 2'd0));
    chk_cnts_zero();
    run_vec("rw_rst2", mkv(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 0, O_RST, 2'd0));
    run_vec("rw_after", idle_v);
    run_vec("rw_after2", idle_v);
    exp_lu = 0; exp_mem = 0; exp_fl = 0;
    chk_cnts("after_rw");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic chk_cnts_zero();
    chk("in_reset.lu_stall_cnt", lu_stall_cnt, 32'd0);
    chk("in_reset.mem_stall_cnt", mem_stall_cnt, 32'd0);
    chk("in_reset.flush_cnt", flush_cnt, 32'd0);
  endtask

endmodule
